// File: rtl/basereg_dbg_ctrl.sv
// Debug access sequencer for the base register file. Shares the register file ports with the
// pipeline, and after each debug read it re-issues the saved pipeline read addresses.
module basereg_dbg_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_pipe_ce_read,
  input  logic [AW-1:0]   i_pipe_rs1_addr,
  input  logic [AW-1:0]   i_pipe_rs2_addr,
  input  logic            i_pipe_wr,
  input  logic [AW-1:0]   i_pipe_rd_addr,
  input  logic [XLEN-1:0] i_pipe_rd,
  input  logic            i_halted,
  input  logic            i_dbg_req,
  input  logic            i_dbg_we,
  input  logic [AW-1:0]   i_dbg_addr,
  input  logic [XLEN-1:0] i_dbg_wdata,
  output logic            o_dbg_busy,
  output logic            o_dbg_ack,
  output logic            o_dbg_err,
  output logic [XLEN-1:0] o_dbg_rdata,
  output logic            o_rf_ce_read,
  output logic [AW-1:0]   o_rf_rs1_addr,
  output logic [AW-1:0]   o_rf_rs2_addr,
  output logic            o_rf_wr,
  output logic [AW-1:0]   o_rf_rd_addr,
  output logic [XLEN-1:0] o_rf_rd,
  input  logic [XLEN-1:0] i_rf_rs1
);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdCapture,
    StRestore,
    StWr,
    StErrAck
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     shadow_rs1_q, shadow_rs2_q;
  logic [AW-1:0]     dbg_addr_q;
  logic [XLEN-1:0]   dbg_wdata_q;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q;
  logic              req_accept;

  assign req_accept = (state_q == StIdle) && i_dbg_req;

  // Ack/err are set on the edge that enters the acking cycle, so they appear as registered pulses.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_dbg_req) begin
          if (!i_halted) begin
            state_d = StErrAck;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (i_dbg_we) begin
            state_d = StWr;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      StRdIssue:   state_d = StRdCapture;
      StRdCapture: begin
        state_d = StRestore;
        ack_d   = 1'b1;
      end
      StRestore:   state_d = StIdle;
      StWr: begin
        if (!i_pipe_wr) begin
          state_d = StIdle;
          ack_d   = 1'b1;
        end
      end
      StErrAck:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= StIdle;
      shadow_rs1_q <= '0;
      shadow_rs2_q <= '0;
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if ((state_q == StIdle) && i_pipe_ce_read) begin
        shadow_rs1_q <= i_pipe_rs1_addr;
        shadow_rs2_q <= i_pipe_rs2_addr;
      end
      if (req_accept) begin
        dbg_addr_q  <= i_dbg_addr;
        dbg_wdata_q <= i_dbg_wdata;
      end
      if (state_q == StRdCapture) begin
        rdata_q <= i_rf_rs1;
      end
    end
  end

  // Read port: pipeline owns it only while idle; restore puts its addresses back afterwards.
  always_comb begin
    o_rf_ce_read  = 1'b0;
    o_rf_rs1_addr = shadow_rs1_q;
    o_rf_rs2_addr = shadow_rs2_q;
    unique case (state_q)
      StIdle: begin
        o_rf_ce_read  = i_pipe_ce_read;
        o_rf_rs1_addr = i_pipe_rs1_addr;
        o_rf_rs2_addr = i_pipe_rs2_addr;
      end
      StRdIssue: begin
        o_rf_ce_read  = 1'b1;
        o_rf_rs1_addr = dbg_addr_q;
      end
      StRestore: o_rf_ce_read = 1'b1;
      default:   o_rf_ce_read = 1'b0;
    endcase
  end

  // Write port: writeback always wins; the debug write waits in StWr until the port is free.
  always_comb begin
    o_rf_wr      = 1'b0;
    o_rf_rd_addr = i_pipe_rd_addr;
    o_rf_rd      = i_pipe_rd;
    if (i_pipe_wr) begin
      o_rf_wr = 1'b1;
    end else if (state_q == StWr) begin
      o_rf_wr      = 1'b1;
      o_rf_rd_addr = dbg_addr_q;
      o_rf_rd      = dbg_wdata_q;
    end
  end

  assign o_dbg_busy  = (state_q != StIdle);
  assign o_dbg_ack   = ack_q;
  assign o_dbg_err   = err_q;
  assign o_dbg_rdata = rdata_q;

endmodule

// File: tb/tb_basereg_dbg_ctrl.sv
// Bench for basereg_dbg_ctrl: a simple register file with registered read addresses around the
// DUT, directed scenarios, then random debug transactions checked against a transaction model.
module tb_basereg_dbg_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_pipe_ce_read = 1'b0;
  logic [4:0]  i_pipe_rs1_addr = '0;
  logic [4:0]  i_pipe_rs2_addr = '0;
  logic        i_pipe_wr = 1'b0;
  logic [4:0]  i_pipe_rd_addr = '0;
  logic [31:0] i_pipe_rd = '0;
  logic        i_halted = 1'b0;
  logic        i_dbg_req = 1'b0;
  logic        i_dbg_we = 1'b0;
  logic [4:0]  i_dbg_addr = '0;
  logic [31:0] i_dbg_wdata = '0;
  logic        o_dbg_busy, o_dbg_ack, o_dbg_err;
  logic [31:0] o_dbg_rdata;
  logic        o_rf_ce_read, o_rf_wr;
  logic [4:0]  o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr;
  logic [31:0] o_rf_rd, i_rf_rs1, rf_rs2;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  basereg_dbg_ctrl #(.XLEN(32), .AW(5)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_pipe_ce_read(i_pipe_ce_read), .i_pipe_rs1_addr(i_pipe_rs1_addr),
    .i_pipe_rs2_addr(i_pipe_rs2_addr), .i_pipe_wr(i_pipe_wr),
    .i_pipe_rd_addr(i_pipe_rd_addr), .i_pipe_rd(i_pipe_rd),
    .i_halted(i_halted), .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we),
    .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_busy(o_dbg_busy), .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err),
    .o_dbg_rdata(o_dbg_rdata), .o_rf_ce_read(o_rf_ce_read),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .o_rf_wr(o_rf_wr), .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd(o_rf_rd),
    .i_rf_rs1(i_rf_rs1)
  );

  // Register file environment: registered read addresses, x0 hardwired to zero.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  logic [4:0]  ra1_q = '0;
  logic [4:0]  ra2_q = '0;
  always @(posedge i_clk) begin
    if (o_rf_wr && o_rf_rd_addr != 5'd0) rf_mem[o_rf_rd_addr] <= o_rf_rd;
    if (o_rf_ce_read) begin
      ra1_q <= o_rf_rs1_addr;
      ra2_q <= o_rf_rs2_addr;
    end
  end
  assign i_rf_rs1 = (ra1_q == 5'd0) ? 32'h0 : rf_mem[ra1_q];
  assign rf_rs2   = (ra2_q == 5'd0) ? 32'h0 : rf_mem[ra2_q];

  // Reference model: architectural register contents and last debug read data.
  logic [31:0] model [32] = '{default: 32'h0};
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pipe_write(input logic [4:0] a, input logic [31:0] d);
    i_pipe_wr = 1'b1;
    i_pipe_rd_addr = a;
    i_pipe_rd = d;
    @(negedge i_clk);
    chk("pipe_wr_pass", {26'h0, o_rf_wr, o_rf_rd_addr}, {26'h0, 1'b1, a});
    cyc();
    i_pipe_wr = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  // One debug transaction from cycle 0; observes a 9-cycle window and compares with the model.
  // poke: re-request while busy (must be dropped) and drop halt mid-transaction.
  task automatic run_txn(input bit halted, input bit we, input logic [4:0] addr,
                         input logic [31:0] wdata, input int npipe, input logic [4:0] paddr,
                         input logic [31:0] pdata, input bit poke);
    int ack_cyc = -1, acks = 0, busy_n = 0, ce_n = 0, wr_cyc = -1;
    int exp_ack, exp_busy, exp_ce, exp_wr;
    logic err_s = 1'b0;
    logic [31:0] rd_s = 32'h0;
    logic [31:0] exp_rd;
    i_halted = halted;
    i_dbg_req = 1'b1;
    i_dbg_we = we;
    i_dbg_addr = addr;
    i_dbg_wdata = wdata;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      i_dbg_req = poke && (c == 1);
      if (poke && c == 1) begin
        i_dbg_we = ~we;
        i_dbg_addr = addr + 5'd1;
        i_halted = 1'b0;
      end
      i_pipe_wr = (c <= npipe);
      i_pipe_rd_addr = paddr;
      i_pipe_rd = pdata;
      @(negedge i_clk);
      if (o_dbg_busy) busy_n++;
      if (o_rf_ce_read) ce_n++;
      if (o_rf_wr && !i_pipe_wr && wr_cyc < 0 && o_rf_rd_addr == addr && o_rf_rd == wdata)
        wr_cyc = c;
      if (o_dbg_ack) begin
        acks++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          err_s = o_dbg_err;
          rd_s = o_dbg_rdata;
        end
      end
    end
    cyc();
    i_pipe_wr = 1'b0;
    if (!halted) begin
      exp_ack = 1; exp_busy = 1; exp_ce = 0; exp_wr = -1;
    end else if (we) begin
      if (npipe > 0 && paddr != 5'd0) model[paddr] = pdata;
      if (addr != 5'd0) model[addr] = wdata;
      exp_ack = 2 + npipe; exp_busy = 1 + npipe; exp_ce = 0; exp_wr = 1 + npipe;
    end else begin
      last_rdata = (addr == 5'd0) ? 32'h0 : model[addr];
      exp_ack = 3; exp_busy = 3; exp_ce = 2; exp_wr = -1;
    end
    exp_rd = last_rdata;
    chk("ack_cycle", ack_cyc, exp_ack);
    chk("ack_count", acks, 1);
    chk("err", {31'h0, err_s}, {31'h0, !halted});
    chk("rdata", rd_s, exp_rd);
    chk("busy_cycles", busy_n, exp_busy);
    chk("ce_read_cycles", ce_n, exp_ce);
    chk("dbg_wr_cycle", wr_cyc, exp_wr);
    chk("rf_contents", rf_mem[addr], model[addr]);
  endtask

  initial begin
    repeat (2) cyc();
    @(negedge i_clk);
    chk("rst_busy", {31'h0, o_dbg_busy}, 32'h0);
    chk("rst_ack_err", {30'h0, o_dbg_ack, o_dbg_err}, 32'h0);
    chk("rst_rdata", o_dbg_rdata, 32'h0);
    cyc();
    i_rstn = 1'b1;
    cyc();

    // Read back a value placed by writeback.
    pipe_write(5'd5, 32'h0000_00AA);
    run_txn(1'b1, 1'b0, 5'd5, 32'h0, 0, 5'd0, 32'h0, 1'b0);

    // Pipeline read addresses survive a debug read.
    pipe_write(5'd7, 32'h11);
    pipe_write(5'd9, 32'h22);
    i_pipe_ce_read = 1'b1;
    i_pipe_rs1_addr = 5'd7;
    i_pipe_rs2_addr = 5'd9;
    cyc();
    i_pipe_ce_read = 1'b0;
    i_pipe_rs1_addr = 5'd1;
    i_pipe_rs2_addr = 5'd2;
    run_txn(1'b1, 1'b0, 5'd3, 32'h0, 0, 5'd0, 32'h0, 1'b0);
    @(negedge i_clk);
    chk("restore_rs1", i_rf_rs1, 32'h11);
    chk("restore_rs2", rf_rs2, 32'h22);
    cyc();

    // Uncontended write, then read back.
    run_txn(1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 5'd12, 32'h0, 0, 5'd0, 32'h0, 1'b0);

    // Write contending with writeback to the same register.
    run_txn(1'b1, 1'b1, 5'd4, 32'h1, 2, 5'd4, 32'h2, 1'b0);
    run_txn(1'b1, 1'b0, 5'd4, 32'h0, 0, 5'd0, 32'h0, 1'b0);

    // Rejected while running.
    run_txn(1'b0, 1'b0, 5'd1, 32'h0, 0, 5'd0, 32'h0, 1'b0);

    // Reset during RD_CAPTURE aborts the read.
    i_halted = 1'b1;
    i_dbg_req = 1'b1;
    i_dbg_we = 1'b0;
    i_dbg_addr = 5'd5;
    cyc();
    i_dbg_req = 1'b0;
    cyc();
    i_rstn = 1'b0;
    #1;
    chk("abort_busy", {31'h0, o_dbg_busy}, 32'h0);
    chk("abort_ack", {31'h0, o_dbg_ack}, 32'h0);
    last_rdata = 32'h0;
    cyc();
    i_rstn = 1'b1;
    begin
      int late_acks = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge i_clk);
        if (o_dbg_ack) late_acks++;
        cyc();
      end
      chk("abort_no_ack", late_acks, 0);
    end
    chk("abort_rdata", o_dbg_rdata, 32'h0);

    // x0 stays zero.
    run_txn(1'b1, 1'b1, 5'd0, 32'h5, 0, 5'd0, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      bit h, w, p;
      int np;
      h = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      np = (h && w) ? int'($urandom_range(0, 3)) : 0;
      run_txn(h, w, 5'($urandom_range(0, 31)), $urandom, np, 5'($urandom_range(1, 31)),
              $urandom, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basereg_dbg_ctrl.md
Name: basereg_dbg_ctrl

Overview:
Sequences debug-side access to the base register file while sharing its ports with the pipeline.
- Sits between decode/writeback and the register file.
- Pipeline signals pass straight through while idle.
- While the core is halted, it runs debug read/write transactions.
- The register file has a registered read address, so a debug read would clobber the pipeline's held address. After each debug read, the block re-issues the saved pipeline read addresses.

Parameters:
- XLEN, 32, register data width
- AW, 5, register address width

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_pipe_ce_read  in  1  pipeline read-address capture enable (stage 2)
- i_pipe_rs1_addr  in  AW  pipeline source register 1 address
- i_pipe_rs2_addr  in  AW  pipeline source register 2 address
- i_pipe_wr  in  1  writeback write enable
- i_pipe_rd_addr  in  AW  writeback destination address
- i_pipe_rd  in  XLEN  writeback data
- i_halted  in  1  core halted; debug access permitted
- i_dbg_req  in  1  single-cycle request pulse; sampled only when o_dbg_busy=0
- i_dbg_we  in  1  1=write, 0=read; qualified by i_dbg_req
- i_dbg_addr  in  AW  debug register address
- i_dbg_wdata  in  XLEN  debug write data
- o_dbg_busy  out  1  FSM not in IDLE
- o_dbg_ack  out  1  one-cycle completion pulse
- o_dbg_err  out  1  valid with ack; request rejected
- o_dbg_rdata  out  XLEN  read data; held until next read completes
- o_rf_ce_read  out  1  to register file read enable
- o_rf_rs1_addr  out  AW  to register file
- o_rf_rs2_addr  out  AW  to register file
- o_rf_wr  out  1  to register file write enable
- o_rf_rd_addr  out  AW  to register file
- o_rf_rd  out  XLEN  to register file write data
- i_rf_rs1  in  XLEN  register file rs1 output

Behaviour:
Clock, reset and reset values:
- One clock, i_clk. Reset i_rstn is asynchronous, active-low.
- Reset returns the FSM to IDLE.
- Reset clears shadow rs1/rs2 address registers, latched debug address/data, o_dbg_ack, o_dbg_err and o_dbg_rdata to 0.
- Reset mid-transaction aborts it with no ack.

Shadow addresses:
- When i_pipe_ce_read=1 and the FSM is in IDLE, shadow_rs1/shadow_rs2 <= i_pipe_rs1/rs2_addr.

Read-port mux:
- IDLE: o_rf_ce_read/rs1/rs2 = pipeline inputs (combinational).
- RD_ISSUE: ce_read=1, rs1=latched dbg addr, rs2=shadow_rs2.
- RESTORE: ce_read=1, rs1=shadow_rs1, rs2=shadow_rs2.
- Any other state: ce_read=0.
- i_pipe_ce_read outside IDLE is ignored. Halt must not be released while o_dbg_busy=1.

Write-port mux:
- i_pipe_wr always has priority: if i_pipe_wr=1, o_rf_wr/rd_addr/rd = pipeline inputs in every state.
- In WR with i_pipe_wr=0: o_rf_wr=1, rd_addr/rd = latched debug addr/data.
- Otherwise o_rf_wr=0.

FSM states IDLE, RD_ISSUE, RD_CAPTURE, RESTORE, WR, ERR_ACK. On req in IDLE, latch addr/wdata/we, then:
- req and !i_halted -> ERR_ACK.
- req, i_halted, we=0 -> RD_ISSUE.
- req, i_halted, we=1 -> WR.

Transitions:
- ERR_ACK -> IDLE.
- RD_ISSUE -> RD_CAPTURE.
- RD_CAPTURE: o_dbg_rdata <= i_rf_rs1 at the clock edge; -> RESTORE.
- RESTORE -> IDLE.
- WR -> IDLE when i_pipe_wr=0; stays in WR while i_pipe_wr=1.

Latency (cycle 0 = req in IDLE):
- Read: ack and new rdata at cycle 3, concurrent with RESTORE. busy=1 in cycles 1-3.
- Write: register file written at the end of the first WR cycle with i_pipe_wr=0. Ack the next cycle, so cycle 2 if uncontended.
- Reject: ack=1 and err=1 at cycle 1, no port access. err=0 on every successful ack.

Registered outputs:
- o_dbg_ack/o_dbg_err are registered pulses.
- o_dbg_rdata is unchanged by writes and errors.

Boundary conditions:
- Address 0: a write is acked normally (register file ignores x0); a read returns 0.
- i_halted dropping mid-transaction does not abort it.
- A req while busy is dropped silently.
- RESTORE makes the register file's rs1/rs2 outputs equal the pre-read pipeline values from cycle 4 onward.

Test Plan:
- Halted; writeback wr x5=0x0000_00AA earlier; debug read addr 5 at cycle 0 -> ack at cycle 3, rdata=0x0000_00AA, err=0, busy=1 in cycles 1-3.
- Pipeline captured rs1=7, rs2=9 (x7=0x11, x9=0x22); then debug read x3 -> from cycle 4, register file rs1 output=0x11, rs2 output=0x22.
- Halted; debug write x12=0xDEAD_BEEF -> o_rf_wr=1 at cycle 1 with addr 12; ack at cycle 2; following read of x12 returns 0xDEAD_BEEF.
- Debug write x4=0x1 while i_pipe_wr=1 (x4=0x2) in cycles 1-2 -> pipeline write passes first; debug write at cycle 3, ack at cycle 4; x4 reads 0x1.
- Not halted; debug read x1 -> ack=1, err=1 at cycle 1; no o_rf_ce_read pulse; o_dbg_rdata unchanged.
- i_rstn low during RD_CAPTURE -> busy=0, ack=0 immediately, no ack after release; debug write x0=0x5 then read x0 -> rdata=0.
